// File: rtl/btn_acc_pkg.sv
// Shared types and constants for the button accumulator.
// Button indices, FSM state and op encodings.
package btn_acc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } acc_state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_CLR = 2'd2
  } acc_op_t;

  localparam int BTN_ADD = 0;
  localparam int BTN_SUB = 1;
  localparam int BTN_CLR = 2;

  // Clear wins over add, add wins over subtract
  function automatic acc_op_t pick_op(
    input logic [2:0] p
  );
    acc_op_t op;
    op = OP_SUB;
    if (p[BTN_CLR])
      op = OP_CLR;
    else if (p[BTN_ADD])
      op = OP_ADD;
    return op;
  endfunction

endpackage

// File: rtl/btn_accumulator_if.sv
// Board-side bundle: tick, buttons and switches in,
// display nibbles, LEDs and overflow out.
interface btn_accumulator_if #(
  parameter int W     = 8,
  parameter int N_BTN = 3
);
  logic             tick;
  logic [N_BTN-1:0] btn;
  logic [W-1:0]     sw;
  logic [3:0]       digit0;
  logic [3:0]       digit1;
  logic [3:0]       digit2;
  logic [3:0]       digit3;
  logic [W-1:0]     led;
  logic             ovf;

  modport master (
    output tick, btn, sw,
    input  digit0, digit1, digit2, digit3,
    input  led, ovf
  );

  modport slave (
    input  tick, btn, sw,
    output digit0, digit1, digit2, digit3,
    output led, ovf
  );
endinterface

// File: rtl/btn_debounce.sv
// One button: 2-FF synchroniser, tick-sampled debounce
// counter and rising-edge pulse on the debounced level.
module btn_debounce #(
  parameter int DB_TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DB_TICKS + 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic          prev_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], raw};
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
    end
  end

  // Any sample agreeing with the current level restarts the count
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (tick) begin
      if (sync_q[1] != level_q) begin
        if (cnt_q + 1'b1 == CW'(DB_TICKS)) begin
          level_d = ~level_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  assign level = level_q;
  assign press = level_q & ~prev_q;

endmodule

// File: rtl/btn_accumulator.sv
// Button-driven 8-bit add/sub/clear accumulator feeding
// the four-digit display and LED bank.
module btn_accumulator
  import btn_acc_pkg::*;
#(
  parameter int W        = 8,
  parameter int N_BTN    = 3,
  parameter int DB_TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  btn_accumulator_if.slave bus
);

  logic [N_BTN-1:0] level;
  logic [N_BTN-1:0] press;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce #(
      .DB_TICKS(DB_TICKS)
    ) u_db (
      .clk  (clk),
      .rst  (rst),
      .tick (bus.tick),
      .raw  (bus.btn[i]),
      .level(level[i]),
      .press(press[i])
    );
  end

  acc_state_t   state_q, state_d;
  acc_op_t      op_q, op_d;
  logic [W-1:0] opnd_q, opnd_d;
  logic [W-1:0] acc_q, acc_d;
  logic         ovf_q, ovf_d;
  logic [W:0]   sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      op_q    <= OP_ADD;
      opnd_q  <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (|press) state_d = EXEC;
      EXEC: state_d = HOLD;
      HOLD: if (~|level) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Presses outside IDLE are dropped, not queued
  always_comb begin
    op_d   = op_q;
    opnd_d = opnd_q;
    acc_d  = acc_q;
    ovf_d  = ovf_q;
    sum    = {1'b0, acc_q} + {1'b0, opnd_q};
    if (state_q == IDLE && |press) begin
      op_d   = pick_op(press);
      opnd_d = bus.sw;
    end
    if (state_q == EXEC) begin
      unique case (op_q)
        OP_ADD: begin
          acc_d = sum[W-1:0];
          ovf_d = ovf_q | sum[W];
        end
        OP_SUB: begin
          acc_d = acc_q - opnd_q;
          ovf_d = ovf_q | (opnd_q > acc_q);
        end
        OP_CLR: begin
          acc_d = '0;
          ovf_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.digit0 = acc_q[3:0];
  assign bus.digit1 = acc_q[7:4];
  assign bus.digit2 = bus.sw[3:0];
  assign bus.digit3 = {ovf_q, 1'b0, state_q};
  assign bus.led    = acc_q;
  assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_btn_accumulator.sv
// Scoreboard bench for btn_accumulator: directed button
// sequences with hand-computed acc/ovf results.
module tb_btn_accumulator;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  int   tcnt;

  logic [8:0] sb_q[$];

  btn_accumulator_if #(.W(8), .N_BTN(3)) bus ();

  btn_accumulator #(
    .W(8), .N_BTN(3), .DB_TICKS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    tcnt     = 0;
    bus.tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tcnt     = (tcnt + 1) % 4;
      bus.tick = (tcnt == 0);
    end
  end

  task automatic check(
    input string       name,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               name, got, exp);
    end
  endtask

  // Monitor: result becomes visible on the EXEC->HOLD step
  logic [1:0] prev_st;
  logic [7:0] last_acc;
  logic [8:0] e;
  always @(negedge clk) begin
    if (!rst) begin
      prev_st  = 2'd0;
      last_acc = 8'h00;
    end else begin
      if (bus.digit3[1:0] == 2'd1)
        check("exec_acc_old", 32'(bus.led),
              32'(last_acc));
      if (prev_st == 2'd1 && bus.digit3[1:0] == 2'd2) begin
        if (sb_q.size() == 0) begin
          check("unexpected_op", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("acc", 32'(bus.led), 32'(e[7:0]));
          check("ovf", 32'(bus.ovf), 32'(e[8]));
          check("dig0", 32'(bus.digit0),
                32'(e[3:0]));
          check("dig1", 32'(bus.digit1),
                32'(e[7:4]));
          check("dig3_ovf", 32'(bus.digit3[3]),
                32'(e[8]));
          last_acc = e[7:0];
        end
      end
      prev_st = bus.digit3[1:0];
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Return in the tick-high cycle, just after its rise
  task automatic align_tick();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #2;
      if (bus.tick) break;
    end
  endtask

  task automatic do_op(
    input logic [2:0] mask,
    input logic [7:0] sw,
    input logic [7:0] exp_acc,
    input logic       exp_ovf
  );
    sb_q.push_back({exp_ovf, exp_acc});
    bus.sw = sw;
    align_tick();
    bus.btn = mask;
    wait_clks(32);
    check("hold_dig3", 32'(bus.digit3),
          32'({exp_ovf, 3'b010}));
    bus.btn = 3'b000;
    wait_clks(32);
    check("idle_st", 32'(bus.digit3[1:0]), 32'd0);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b0;
    bus.btn = 3'b000;
    bus.sw  = 8'h00;

    for (int i = 0; i < 6; i++) begin
      bus.btn = (i % 2 == 0) ? 3'b111 : 3'b000;
      wait_clks(9);
    end
    bus.btn = 3'b000;
    check("rst_led", 32'(bus.led), 32'h0);
    check("rst_ovf", 32'(bus.ovf), 32'h0);
    check("rst_dig3", 32'(bus.digit3), 32'h0);
    check("rst_dig0", 32'(bus.digit0), 32'h0);
    rst = 1'b1;
    wait_clks(40);
    check("post_rst_led", 32'(bus.led), 32'h0);
    check("post_rst_st", 32'(bus.digit3), 32'h0);

    bus.sw = 8'h05;
    check("dig2_pass", 32'(bus.digit2), 32'h5);
    align_tick();
    bus.btn = 3'b001;
    wait_clks(12);
    bus.btn = 3'b000;
    wait_clks(32);
    check("glitch_led", 32'(bus.led), 32'h0);
    check("glitch_st", 32'(bus.digit3), 32'h0);

    do_op(3'b001, 8'h05, 8'h05, 1'b0);
    do_op(3'b001, 8'hEB, 8'hF0, 1'b0);
    do_op(3'b001, 8'h20, 8'h10, 1'b1);
    do_op(3'b001, 8'h01, 8'h11, 1'b1);
    do_op(3'b100, 8'h00, 8'h00, 1'b0);
    do_op(3'b001, 8'h03, 8'h03, 1'b0);
    do_op(3'b010, 8'h05, 8'hFE, 1'b1);

    sb_q.push_back({1'b0, 8'h00});
    bus.sw = 8'h77;
    align_tick();
    bus.btn = 3'b101;
    wait_clks(32);
    bus.btn = 3'b011;
    wait_clks(32);
    check("hold_ign_st", 32'(bus.digit3), 32'h2);
    check("hold_ign_led", 32'(bus.led), 32'h0);
    bus.btn = 3'b000;
    wait_clks(32);
    check("prio_end_led", 32'(bus.led), 32'h0);

    do_op(3'b001, 8'h40, 8'h40, 1'b0);
    bus.sw = 8'h10;
    align_tick();
    bus.btn = 3'b001;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
        @(posedge clk);
        #1;
        if (bus.digit3[1:0] == 2'd1) begin
          seen = 1'b1;
          break;
        end
      end
      check("exec_reached", 32'(seen), 32'd1);
    end
    #1;
    rst = 1'b0;
    #1;
    check("arst_led", 32'(bus.led), 32'h0);
    check("arst_dig3", 32'(bus.digit3), 32'h0);
    bus.btn = 3'b000;
    wait_clks(4);
    rst = 1'b1;
    wait_clks(48);
    check("arst_after_led", 32'(bus.led), 32'h0);
    check("arst_after_st", 32'(bus.digit3), 32'h0);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
